// File: rtl/demux_1_to_4_buffered_pkg.sv
// Shared definitions for the buffered 1-to-4 demux: channel select codes,
// per-channel FIFO depth and occupancy width.
package demux_1_to_4_buffered_pkg;

  typedef enum logic [1:0] {
    CH0 = 2'b00,
    CH1 = 2'b01,
    CH2 = 2'b10,
    CH3 = 2'b11
  } ch_sel_e;

  localparam int unsigned NUM_CH = 4;
  localparam int unsigned DEPTH  = 2;
  localparam int unsigned OCC_W  = 2;

endpackage

// File: rtl/demux_chan_fifo.sv
// Two-entry per-channel FIFO with registered storage, head output and
// occupancy count; an empty FIFO never bypasses the write data.
module demux_chan_fifo
  import demux_1_to_4_buffered_pkg::*;
#(
  parameter int unsigned WIDTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] data,
  output logic             valid,
  output logic [OCC_W-1:0] occ
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic             wr_ptr;
  logic             rd_ptr;
  logic             do_pop;
  logic             do_push;

  assign valid   = (occ != '0);
  assign do_pop  = pop & valid;
  assign do_push = push & ((occ < OCC_W'(DEPTH)) | do_pop);

  // While empty, the slot behind the read pointer still holds the word that
  // was last presented, so the output keeps its last value without a register.
  assign data = valid ? mem[rd_ptr] : mem[~rd_ptr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      occ    <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (do_pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({do_push, do_pop})
        2'b10:   occ <= occ + OCC_W'(1);
        2'b01:   occ <= occ - OCC_W'(1);
        default: occ <= occ;
      endcase
    end
  end

endmodule

// File: rtl/demux_1_to_4_buffered.sv
// Routes one valid/ready word stream to one of four buffered channels chosen
// per word by in_sel; holds only the select decode and in_ready logic.
module demux_1_to_4_buffered
  import demux_1_to_4_buffered_pkg::*;
#(
  parameter int unsigned WIDTH = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [WIDTH-1:0]        in_data,
  input  logic [1:0]              in_sel,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [NUM_CH*WIDTH-1:0] out_data,
  output logic [NUM_CH-1:0]       out_valid,
  input  logic [NUM_CH-1:0]       out_ready,
  output logic [NUM_CH*OCC_W-1:0] out_occ
);

  ch_sel_e          sel;
  logic [OCC_W-1:0] occ [NUM_CH];
  logic             accept;

  assign sel = ch_sel_e'(in_sel);

  // A full channel still accepts when its head is drained in the same cycle.
  assign in_ready = ~reset & ((occ[sel] < OCC_W'(DEPTH)) | out_ready[sel]);
  assign accept   = in_valid & in_ready;

  for (genvar k = 0; k < NUM_CH; k++) begin : g_chan
    demux_chan_fifo #(
      .WIDTH (WIDTH)
    ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (accept & (sel == ch_sel_e'(k))),
      .push_data (in_data),
      .pop       (out_ready[k]),
      .data      (out_data[k*WIDTH +: WIDTH]),
      .valid     (out_valid[k]),
      .occ       (occ[k])
    );
    assign out_occ[k*OCC_W +: OCC_W] = occ[k];
  end

endmodule

// File: tb/tb_demux_1_to_4_buffered.sv
// Directed bench for demux_1_to_4_buffered with per-channel scoreboard queues
// and an occupancy model derived from queue sizes.
module tb_demux_1_to_4_buffered;

  localparam int W = 2;

  logic         clk = 1'b0;
  logic         reset;
  logic [W-1:0] in_data;
  logic [1:0]   in_sel;
  logic         in_valid;
  logic         in_ready;
  logic [4*W-1:0] out_data;
  logic [3:0]   out_valid;
  logic [3:0]   out_ready;
  logic [7:0]   out_occ;

  int tests = 0;
  int fails = 0;

  logic [W-1:0] q [4][$];

  demux_1_to_4_buffered #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_data   (in_data),
    .in_sel    (in_sel),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_occ   (out_occ)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: compare outputs against the model at the falling edge, then
  // apply the transfers the model predicts at the following rising edge.
  task automatic cycle();
    logic       exp_rdy;
    logic       acc;
    logic [3:0] pop;
    logic [1:0] sel;
    logic [W-1:0] dat;
    @(negedge clk);
    sel = in_sel;
    dat = in_data;
    exp_rdy = !reset && (q[sel].size() < 2 || out_ready[sel]);
    check("in_ready", 32'(in_ready), 32'(exp_rdy));
    for (int k = 0; k < 4; k++) begin
      check($sformatf("out_valid[%0d]", k), 32'(out_valid[k]), 32'(q[k].size() > 0));
      check($sformatf("out_occ[%0d]", k), 32'(out_occ[2*k +: 2]), 32'(q[k].size()));
      if (q[k].size() > 0)
        check($sformatf("out_data[%0d]", k), 32'(out_data[k*W +: W]), 32'(q[k][0]));
      pop[k] = !reset && q[k].size() > 0 && out_ready[k];
    end
    acc = in_valid && exp_rdy;
    @(posedge clk);
    if (reset) begin
      for (int k = 0; k < 4; k++) q[k].delete();
    end else begin
      for (int k = 0; k < 4; k++) if (pop[k]) void'(q[k].pop_front());
      if (acc) q[sel].push_back(dat);
    end
    #1;
  endtask

  task automatic drive(input logic v, input logic [1:0] s, input logic [W-1:0] d);
    in_valid = v;
    in_sel   = s;
    in_data  = d;
  endtask

  initial begin
    reset = 1'b1;
    drive(1'b0, 2'd0, '0);
    out_ready = 4'b0000;
    repeat (2) cycle();
    reset = 1'b0;

    // Reset state and in_ready with each selector while idle
    @(negedge clk);
    check("reset_out_data", 32'(out_data), 32'h0);
    check("reset_out_occ", 32'(out_occ), 32'h0);
    @(posedge clk); #1;
    for (int s = 0; s < 4; s++) begin
      drive(1'b0, 2'(s), '0);
      cycle();
    end

    // One word per channel, all consumers ready
    out_ready = 4'b1111;
    drive(1'b1, 2'd0, 2'b01); cycle();
    drive(1'b1, 2'd1, 2'b10); cycle();
    drive(1'b1, 2'd2, 2'b11); cycle();
    drive(1'b1, 2'd3, 2'b00); cycle();
    drive(1'b0, 2'd0, '0);
    repeat (2) cycle();

    // Channel 2 stalled: fill, stall, serve ch0, then same-cycle drain+accept
    out_ready = 4'b1011;
    drive(1'b1, 2'd2, 2'b01); cycle();
    drive(1'b1, 2'd2, 2'b10); cycle();
    drive(1'b1, 2'd2, 2'b11); cycle();
    drive(1'b1, 2'd0, 2'b01); cycle();
    drive(1'b1, 2'd2, 2'b11);
    out_ready = 4'b1111;
    cycle();
    drive(1'b0, 2'd0, '0);
    repeat (4) cycle();

    // Channel 1 full with continuous drain: six back-to-back words
    out_ready = 4'b1101;
    drive(1'b1, 2'd1, 2'b00); cycle();
    drive(1'b1, 2'd1, 2'b01); cycle();
    out_ready = 4'b1111;
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 2'd1, 2'(i + 2));
      cycle();
    end
    drive(1'b0, 2'd0, '0);
    repeat (3) cycle();

    // Fill ch0, then assert reset between edges
    out_ready = 4'b0000;
    drive(1'b1, 2'd0, 2'b10); cycle();
    drive(1'b1, 2'd0, 2'b11); cycle();
    drive(1'b0, 2'd0, '0);
    #2 reset = 1'b1;
    #1;
    check("async_out_valid", 32'(out_valid), 32'h0);
    check("async_out_occ", 32'(out_occ), 32'h0);
    check("async_in_ready", 32'(in_ready), 32'h0);
    for (int k = 0; k < 4; k++) q[k].delete();
    cycle();
    reset = 1'b0;
    out_ready = 4'b1111;
    repeat (3) cycle();

    // Stalled producer toggling between full ch3 and empty ch1
    out_ready = 4'b0111;
    drive(1'b1, 2'd3, 2'b01); cycle();
    drive(1'b1, 2'd3, 2'b10); cycle();
    drive(1'b1, 2'd3, 2'b11); cycle();
    drive(1'b1, 2'd1, 2'b11); cycle();
    drive(1'b1, 2'd3, 2'b00); cycle();
    drive(1'b0, 2'd0, '0);
    cycle();
    out_ready = 4'b1111;
    repeat (4) cycle();

    for (int k = 0; k < 4; k++)
      check($sformatf("drained[%0d]", k), 32'(q[k].size()), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
